// File: rtl/mem_pipe_rd.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pipe_rd
//  Brief    : Pipelined main-memory model with fixed read latency.
//             One request per cycle, no back-pressure, in-order returns.
//  Revision : 1.0  initial release
// ============================================================================
module mem_pipe_rd #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 32768
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       data_in,
    output logic [15:0]       data_out,
    output logic              data_valid,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        outstanding
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [15:0]       mem [DEPTH];
    logic [IDX_W-1:0]  w_idx;
    logic [15:0]       w_rd_data;
    logic              w_rd;
    logic              w_unused_lsb;

    logic [LATENCY-1:0] r_vld;
    logic [15:0]        r_dat [LATENCY];
    logic [ADDR_W-1:0]  r_adr [LATENCY];

    assign w_unused_lsb = addr[0];
    // Word index wraps modulo DEPTH so any address maps somewhere.
    assign w_idx     = IDX_W'(32'(addr[ADDR_W-1:1]) % DEPTH);
    assign w_rd      = enable & ~wr;
    assign w_rd_data = mem[w_idx];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (enable && wr) begin
            mem[w_idx] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_dat[i] <= '0;
                r_adr[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_rd;
            // Stage 1 captures only on a real read, keeping idle-cycle inputs out.
            if (w_rd) begin
                r_dat[0] <= w_rd_data;
                r_adr[0] <= {addr[ADDR_W-1:1], 1'b0};
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                // Output stage only loads on valid so data_out holds across bubbles.
                if ((i < LATENCY - 1) || r_vld[i-1]) begin
                    r_dat[i] <= r_dat[i-1];
                    r_adr[i] <= r_adr[i-1];
                end
            end
        end
    end

    assign data_valid  = r_vld[LATENCY-1];
    assign data_out    = r_dat[LATENCY-1];
    assign data_addr   = r_adr[LATENCY-1];
    assign outstanding = 4'($countones(r_vld));

endmodule
`default_nettype wire

// File: tb/tb_mem_pipe_rd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_pipe_rd
//  Brief    : Scoreboard bench for mem_pipe_rd; default instance plus a
//             LATENCY=1 / DEPTH=16 instance driven with identical stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_pipe_rd;

    localparam int LAT0 = 4;
    localparam int DEP0 = 32768;
    localparam int LAT1 = 1;
    localparam int DEP1 = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;

    logic [15:0] d0_out, d1_out, a0_out, a1_out;
    logic        v0, v1;
    logic [3:0]  o0, o1;

    typedef struct {
        int          due;
        logic [15:0] d;
        logic        known;
        logic [15:0] a;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] m0 [int];
    logic [15:0] m1 [int];
    int          cyc    = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mem_pipe_rd #(.LATENCY(LAT0), .ADDR_W(16), .DEPTH(DEP0)) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(d0_out), .data_valid(v0),
        .data_addr(a0_out), .outstanding(o0)
    );

    mem_pipe_rd #(.LATENCY(LAT1), .ADDR_W(16), .DEPTH(DEP1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(d1_out), .data_valid(v1),
        .data_addr(a1_out), .outstanding(o1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a word store per instance and a list of pending returns.
    always @(posedge clk) begin
        int i0, i1;
        exp_t e;
        cyc = cyc + 1;
        if (rst === 1'b1 && enable === 1'b1) begin
            i0 = int'(addr[15:1]) % DEP0;
            i1 = int'(addr[15:1]) % DEP1;
            if (wr) begin
                m0[i0] = data_in;
                m1[i1] = data_in;
            end else begin
                e.a     = {addr[15:1], 1'b0};
                e.due   = cyc + LAT0 - 1;
                e.known = m0.exists(i0);
                e.d     = e.known ? m0[i0] : 16'h0;
                q0.push_back(e);
                e.due   = cyc + LAT1 - 1;
                e.known = m1.exists(i1);
                e.d     = e.known ? m1[i1] : 16'h0;
                q1.push_back(e);
            end
        end
    end

    // Reset drops every read in flight.
    always @(negedge rst) begin
        q0.delete();
        q1.delete();
    end

    task automatic mon(input int k, input logic v, input logic [15:0] d,
                       input logic [15:0] a, input logic [3:0] o);
        exp_t e;
        int   n;
        n = (k == 0) ? q0.size() : q1.size();
        chk($sformatf("outstanding%0d", k), int'(o), n);
        if (n > 0) e = (k == 0) ? q0[0] : q1[0];
        if (v) begin
            if (n == 0) begin
                chk($sformatf("valid_without_read%0d", k), int'(v), 0);
            end else begin
                if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                chk($sformatf("return_cycle%0d", k), cyc, e.due);
                if (e.known) chk($sformatf("data%0d", k), int'(d), int'(e.d));
                chk($sformatf("data_addr%0d", k), int'(a), int'(e.a));
            end
        end else if (n > 0 && e.due <= cyc) begin
            chk($sformatf("missing_valid%0d", k), int'(v), 1);
            if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
    endtask

    always @(negedge clk) begin
        mon(0, v0, d0_out, a0_out, o0);
        mon(1, v1, d1_out, a1_out, o1);
    end

    task automatic drive(input logic en, input logic w, input logic [15:0] a,
                         input logic [15:0] d);
        @(posedge clk);
        #1;
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid0", int'(v0), 0);
        chk("rst_data0", int'(d0_out), 0);
        chk("rst_addr0", int'(a0_out), 0);
        chk("rst_outst0", int'(o0), 0);
        chk("rst_valid1", int'(v1), 0);
        chk("rst_data1", int'(d1_out), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 64; i++) drive(1'b1, 1'b1, 16'(i * 2), 16'($urandom));
        drive(1'b1, 1'b1, 16'h0100, 16'hBEEF);
        idle(1);
        drive(1'b1, 1'b0, 16'h0100, 16'h0);
        idle(6);

        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 16'(16'h0230 + i * 2), 16'($urandom));
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 16'(16'h0230 + i * 2), 16'h0);
        idle(6);

        drive(1'b1, 1'b1, 16'h0040, 16'h1234);
        drive(1'b1, 1'b0, 16'h0040, 16'h0);
        drive(1'b1, 1'b1, 16'h0040, 16'h5678);
        drive(1'b1, 1'b0, 16'h0040, 16'h0);
        drive(1'b1, 1'b0, 16'h0041, 16'h0);
        idle(6);

        drive(1'b1, 1'b1, 16'h0000, 16'hAAAA);
        drive(1'b1, 1'b1, 16'h0020, 16'h5555);
        drive(1'b1, 1'b0, 16'h0000, 16'h0);
        drive(1'b1, 1'b0, 16'h0020, 16'h0);
        idle(1);
        drive(1'b1, 1'b0, 16'h0002, 16'h0);
        idle(6);

        drive(1'b1, 1'b0, 16'h0010, 16'h0);
        drive(1'b1, 1'b0, 16'h0012, 16'h0);
        drive(1'b1, 1'b0, 16'h0014, 16'h0);
        @(posedge clk);
        #1 rst = 1'b0; enable = 1'b0;
        #1 chk("rst_mid_outst0", int'(o0), 0);
        chk("rst_mid_valid0", int'(v0), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        drive(1'b1, 1'b0, 16'h0016, 16'h0);
        idle(6);

        for (int t = 0; t < 400; t++) begin
            case ($urandom_range(0, 3))
                0:       idle(1);
                1:       drive(1'b1, 1'b1, 16'($urandom_range(0, 127)), 16'($urandom));
                default: drive(1'b1, 1'b0, 16'($urandom_range(0, 127)), 16'h0);
            endcase
        end
        idle(LAT0 + 4);
        @(negedge clk);
        #1;
        chk("drain0", q0.size(), 0);
        chk("drain1", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
